// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one unified memory between the CPU port (C) and a debug/loader port (D).
// Round-robin on ties, fixed ACC_CYCLES access window, completion pulse and CPU stall.
module mem_port_arbiter #(
    parameter int unsigned ACC_CYCLES = 1,
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              cpu_req_i,
    input  logic              cpu_we_i,
    input  logic [ADDR_W-1:0] cpu_addr_i,
    input  logic [DATA_W-1:0] cpu_wdata_i,
    output logic              cpu_gnt_o,
    output logic              cpu_done_o,
    output logic [DATA_W-1:0] cpu_rdata_o,
    output logic              cpu_stall_o,
    input  logic              dbg_req_i,
    input  logic              dbg_we_i,
    input  logic [ADDR_W-1:0] dbg_addr_i,
    input  logic [DATA_W-1:0] dbg_wdata_i,
    input  logic              dbg_lock_i,
    output logic              dbg_gnt_o,
    output logic              dbg_done_o,
    output logic [DATA_W-1:0] dbg_rdata_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    output logic              mem_read_o,
    output logic              mem_write_o,
    input  logic [DATA_W-1:0] mem_rdata_i
);

    typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

    localparam int unsigned CntW = 4;
    localparam logic [CntW-1:0] CntInit = CntW'(ACC_CYCLES - 1);

    state_e            state_q, state_d;
    logic              owner_q, owner_d;  // 1 = port D
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              first_q, first_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [DATA_W-1:0] dbg_rdata_q, dbg_rdata_d;

    logic elig_c, elig_d, pick_d, in_access, in_done;

    assign elig_c = cpu_req_i & ~dbg_lock_i;
    assign elig_d = dbg_req_i;
    // D wins when it is alone, or on a tie when C owned the previous access.
    assign pick_d = elig_d & (~elig_c | ~owner_q);

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        cnt_d       = cnt_q;
        first_d     = first_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        cpu_rdata_d = cpu_rdata_q;
        dbg_rdata_d = dbg_rdata_q;
        unique case (state_q)
            StIdle, StDone: begin
                if (elig_c | elig_d) begin
                    state_d = StAccess;
                    owner_d = pick_d;
                    cnt_d   = CntInit;
                    first_d = 1'b1;
                    we_d    = pick_d ? dbg_we_i    : cpu_we_i;
                    addr_d  = pick_d ? dbg_addr_i  : cpu_addr_i;
                    wdata_d = pick_d ? dbg_wdata_i : cpu_wdata_i;
                end else begin
                    state_d = StIdle;
                end
            end
            StAccess: begin
                first_d = 1'b0;
                if (cnt_q == '0) begin
                    state_d = StDone;
                    if (!we_q) begin
                        if (owner_q) dbg_rdata_d = mem_rdata_i;
                        else         cpu_rdata_d = mem_rdata_i;
                    end
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= StIdle;
            owner_q     <= 1'b1;
            cnt_q       <= '0;
            first_q     <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            cpu_rdata_q <= '0;
            dbg_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            cnt_q       <= cnt_d;
            first_q     <= first_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            cpu_rdata_q <= cpu_rdata_d;
            dbg_rdata_q <= dbg_rdata_d;
        end
    end

    assign in_access = (state_q == StAccess);
    assign in_done   = (state_q == StDone);

    assign cpu_gnt_o   = in_access & first_q & ~owner_q;
    assign dbg_gnt_o   = in_access & first_q & owner_q;
    assign cpu_done_o  = in_done & ~owner_q;
    assign dbg_done_o  = in_done & owner_q;
    assign cpu_rdata_o = cpu_rdata_q;
    assign dbg_rdata_o = dbg_rdata_q;
    assign cpu_stall_o = cpu_req_i | (in_access & ~owner_q);

    assign mem_addr_o  = in_access ? addr_q : '0;
    assign mem_wdata_o = in_access ? wdata_q : '0;
    assign mem_read_o  = in_access & ~we_q;
    assign mem_write_o = in_access & first_q & we_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: two instances (ACC_CYCLES 1 and 3), a timeline-based model
// checked every cycle, directed scenarios with literal expectations, then random traffic.
module tb_mem_port_arbiter;

    logic        clk;
    logic        rst       [2];
    logic        cpu_req   [2];
    logic        cpu_we    [2];
    logic [31:0] cpu_addr  [2];
    logic [31:0] cpu_wdata [2];
    logic        cpu_gnt   [2];
    logic        cpu_done  [2];
    logic [31:0] cpu_rdata [2];
    logic        cpu_stall [2];
    logic        dbg_req   [2];
    logic        dbg_we    [2];
    logic [31:0] dbg_addr  [2];
    logic [31:0] dbg_wdata [2];
    logic        dbg_lock  [2];
    logic        dbg_gnt   [2];
    logic        dbg_done  [2];
    logic [31:0] dbg_rdata [2];
    logic [31:0] mem_addr  [2];
    logic [31:0] mem_wdata [2];
    logic        mem_read  [2];
    logic        mem_write [2];
    logic [31:0] mem_rdata [2];

    int total = 0;
    int bad   = 0;

    function automatic logic [31:0] mfun(input logic [31:0] a);
        if (a == 32'h4) return 32'h8C02_0000;
        return (a * 32'h9E37_79B1) ^ 32'h3C6E_F372;
    endfunction

    assign mem_rdata[0] = mfun(mem_addr[0]);
    assign mem_rdata[1] = mfun(mem_addr[1]);

    mem_port_arbiter #(.ACC_CYCLES(1), .ADDR_W(32), .DATA_W(32)) u_dut_a1 (
        .clk_i(clk), .reset_i(rst[0]),
        .cpu_req_i(cpu_req[0]), .cpu_we_i(cpu_we[0]), .cpu_addr_i(cpu_addr[0]),
        .cpu_wdata_i(cpu_wdata[0]), .cpu_gnt_o(cpu_gnt[0]), .cpu_done_o(cpu_done[0]),
        .cpu_rdata_o(cpu_rdata[0]), .cpu_stall_o(cpu_stall[0]),
        .dbg_req_i(dbg_req[0]), .dbg_we_i(dbg_we[0]), .dbg_addr_i(dbg_addr[0]),
        .dbg_wdata_i(dbg_wdata[0]), .dbg_lock_i(dbg_lock[0]), .dbg_gnt_o(dbg_gnt[0]),
        .dbg_done_o(dbg_done[0]), .dbg_rdata_o(dbg_rdata[0]),
        .mem_addr_o(mem_addr[0]), .mem_wdata_o(mem_wdata[0]), .mem_read_o(mem_read[0]),
        .mem_write_o(mem_write[0]), .mem_rdata_i(mem_rdata[0])
    );

    mem_port_arbiter #(.ACC_CYCLES(3), .ADDR_W(32), .DATA_W(32)) u_dut_a3 (
        .clk_i(clk), .reset_i(rst[1]),
        .cpu_req_i(cpu_req[1]), .cpu_we_i(cpu_we[1]), .cpu_addr_i(cpu_addr[1]),
        .cpu_wdata_i(cpu_wdata[1]), .cpu_gnt_o(cpu_gnt[1]), .cpu_done_o(cpu_done[1]),
        .cpu_rdata_o(cpu_rdata[1]), .cpu_stall_o(cpu_stall[1]),
        .dbg_req_i(dbg_req[1]), .dbg_we_i(dbg_we[1]), .dbg_addr_i(dbg_addr[1]),
        .dbg_wdata_i(dbg_wdata[1]), .dbg_lock_i(dbg_lock[1]), .dbg_gnt_o(dbg_gnt[1]),
        .dbg_done_o(dbg_done[1]), .dbg_rdata_o(dbg_rdata[1]),
        .mem_addr_o(mem_addr[1]), .mem_wdata_o(mem_wdata[1]), .mem_read_o(mem_read[1]),
        .mem_write_o(mem_write[1]), .mem_rdata_i(mem_rdata[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %h want %h", nm, $time, got, exp);
        end
    endtask

    // Model: each access is a timeline of ACC cycles of ACCESS (age 1..ACC) then DONE.
    bit          m_valid [2] = '{0, 0};
    bit          m_busy  [2];
    int          m_age   [2];
    bit          m_own   [2];
    bit          m_we    [2];
    logic [31:0] m_addr  [2];
    logic [31:0] m_wdata [2];
    logic [31:0] m_crd   [2];
    logic [31:0] m_drd   [2];

    always @(negedge clk) begin : model
        int acc;
        bit ina, dn, fst, ec, ed;
        for (int k = 0; k < 2; k++) begin
            acc = (k == 0) ? 1 : 3;
            ina = m_busy[k] && m_age[k] <= acc;
            dn  = m_busy[k] && m_age[k] == acc + 1;
            fst = m_busy[k] && m_age[k] == 1;
            if (m_valid[k]) begin
                chk($sformatf("i%0d_cpu_gnt", k),   cpu_gnt[k],   fst & ~m_own[k]);
                chk($sformatf("i%0d_dbg_gnt", k),   dbg_gnt[k],   fst & m_own[k]);
                chk($sformatf("i%0d_cpu_done", k),  cpu_done[k],  dn & ~m_own[k]);
                chk($sformatf("i%0d_dbg_done", k),  dbg_done[k],  dn & m_own[k]);
                chk($sformatf("i%0d_mem_read", k),  mem_read[k],  ina & ~m_we[k]);
                chk($sformatf("i%0d_mem_write", k), mem_write[k], fst & m_we[k]);
                chk($sformatf("i%0d_mem_addr", k),  mem_addr[k],  ina ? m_addr[k] : 32'h0);
                chk($sformatf("i%0d_mem_wdata", k), mem_wdata[k], ina ? m_wdata[k] : 32'h0);
                chk($sformatf("i%0d_cpu_rdata", k), cpu_rdata[k], m_crd[k]);
                chk($sformatf("i%0d_dbg_rdata", k), dbg_rdata[k], m_drd[k]);
                chk($sformatf("i%0d_cpu_stall", k), cpu_stall[k],
                    (cpu_req[k] & ~(ina & ~m_own[k])) | (ina & ~m_own[k]));
            end
            if (rst[k] === 1'b1) begin
                m_valid[k] = 1;
                m_busy[k]  = 0;
                m_age[k]   = 0;
                m_own[k]   = 1;
                m_crd[k]   = 32'h0;
                m_drd[k]   = 32'h0;
            end else if (m_valid[k]) begin
                if (ina) begin
                    if (m_age[k] == acc && !m_we[k]) begin
                        if (m_own[k]) m_drd[k] = mfun(m_addr[k]);
                        else          m_crd[k] = mfun(m_addr[k]);
                    end
                    m_age[k]++;
                end else begin
                    ec = cpu_req[k] & ~dbg_lock[k];
                    ed = dbg_req[k];
                    if (ec || ed) begin
                        m_own[k]   = (ec && ed) ? !m_own[k] : ed;
                        m_busy[k]  = 1;
                        m_age[k]   = 1;
                        m_we[k]    = m_own[k] ? dbg_we[k]    : cpu_we[k];
                        m_addr[k]  = m_own[k] ? dbg_addr[k]  : cpu_addr[k];
                        m_wdata[k] = m_own[k] ? dbg_wdata[k] : cpu_wdata[k];
                    end else begin
                        m_busy[k] = 0;
                    end
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic new_c(input int k);
        cpu_req[k]   = 1'b1;
        cpu_we[k]    = 1'($urandom_range(1));
        cpu_addr[k]  = ($urandom_range(3) == 0) ? 32'h4 : $urandom;
        cpu_wdata[k] = $urandom;
    endtask

    task automatic new_d(input int k);
        dbg_req[k]   = 1'b1;
        dbg_we[k]    = 1'($urandom_range(1));
        dbg_addr[k]  = ($urandom_range(3) == 0) ? 32'h4 : $urandom;
        dbg_wdata[k] = $urandom;
    endtask

    initial begin : stim
        int nw, done_at, ng, found, nd;
        int gseq[$];
        logic [31:0] ad [3];
        logic [31:0] exp_rd [3];
        for (int k = 0; k < 2; k++) begin
            rst[k] = 1'b1; cpu_req[k] = 0; cpu_we[k] = 0; cpu_addr[k] = 0; cpu_wdata[k] = 0;
            dbg_req[k] = 0; dbg_we[k] = 0; dbg_addr[k] = 0; dbg_wdata[k] = 0; dbg_lock[k] = 0;
        end
        repeat (2) cyc();

        // CPU read, ACC=1
        rst[0] = 0; rst[1] = 0;
        cpu_req[0] = 1; cpu_we[0] = 0; cpu_addr[0] = 32'h4;
        @(negedge clk);
        chk("d1_stall_c0", cpu_stall[0], 1);
        chk("d1_gnt_c0", cpu_gnt[0], 0);
        cyc();
        @(negedge clk);
        chk("d1_gnt_c1", cpu_gnt[0], 1);
        chk("d1_read_c1", mem_read[0], 1);
        chk("d1_addr_c1", mem_addr[0], 32'h4);
        chk("d1_stall_c1", cpu_stall[0], 1);
        cyc();
        cpu_req[0] = 0;
        @(negedge clk);
        chk("d1_done_c2", cpu_done[0], 1);
        chk("d1_rdata_c2", cpu_rdata[0], 32'h8C02_0000);
        chk("d1_stall_c2", cpu_stall[0], 0);

        // Debug write, ACC=3
        cyc();
        dbg_req[1] = 1; dbg_we[1] = 1; dbg_addr[1] = 32'h100; dbg_wdata[1] = 32'hDEAD_BEEF;
        nw = 0; done_at = -1;
        for (int c = 0; c < 5; c++) begin
            if (c > 0) begin
                cyc();
                if (c == 2) dbg_req[1] = 0;
            end
            @(negedge clk);
            chk("d2_read_low", mem_read[1], 0);
            if (mem_write[1]) begin
                nw++;
                chk("d2_waddr", mem_addr[1], 32'h100);
                chk("d2_wdata", mem_wdata[1], 32'hDEAD_BEEF);
            end
            if (dbg_done[1]) done_at = c;
        end
        chk("d2_write_count", nw, 1);
        chk("d2_done_cycle", done_at, 4);
        chk("d2_rdata_kept", dbg_rdata[1], 32'h0);

        // Tie alternation, ACC=1, starting from reset
        cyc(); rst[0] = 1;
        cyc(); rst[0] = 0;
        cpu_req[0] = 1; cpu_addr[0] = 32'h10; dbg_req[0] = 1; dbg_we[0] = 0; dbg_addr[0] = 32'h20;
        for (int c = 0; c < 10; c++) begin
            if (c > 0) cyc();
            @(negedge clk);
            if (cpu_gnt[0]) gseq.push_back(0);
            if (dbg_gnt[0]) gseq.push_back(1);
        end
        cyc(); cpu_req[0] = 0; dbg_req[0] = 0;
        chk("d3_grant_count", gseq.size(), 5);
        for (int i = 0; i < gseq.size() && i < 5; i++)
            chk($sformatf("d3_grant_%0d", i), gseq[i], i % 2);

        // Lock: CPU starved while debug keeps running, ACC=3
        cyc();
        dbg_lock[1] = 1; cpu_req[1] = 1; cpu_we[1] = 0; cpu_addr[1] = 32'h30;
        dbg_req[1] = 1; dbg_we[1] = 0; dbg_addr[1] = 32'h4;
        ng = 0;
        for (int c = 0; c < 10; c++) begin
            if (c > 0) cyc();
            @(negedge clk);
            chk("d4_no_cpu_gnt", cpu_gnt[1], 0);
            chk("d4_stall_high", cpu_stall[1], 1);
            if (dbg_gnt[1]) ng++;
        end
        chk("d4_dbg_grants", ng, 3);
        chk("d4_dbg_rdata", dbg_rdata[1], 32'h8C02_0000);
        found = -1;
        for (int w = 0; w < 10 && found < 0; w++) begin
            cyc();
            if (w == 0) begin dbg_lock[1] = 0; dbg_req[1] = 0; end
            @(negedge clk);
            if (cpu_gnt[1]) found = w;
        end
        chk("d4_gnt_after_unlock", found, 3);
        cyc(); cpu_req[1] = 0;
        repeat (4) cyc();

        // Reset in the second ACCESS cycle of a CPU read, ACC=3
        rst[1] = 1;
        cyc(); rst[1] = 0;
        cpu_req[1] = 1; cpu_we[1] = 0; cpu_addr[1] = 32'h40;
        cyc();
        @(negedge clk);
        chk("d5_gnt", cpu_gnt[1], 1);
        cyc(); rst[1] = 1; cpu_req[1] = 0;
        @(negedge clk);
        chk("d5_read_before_rst", mem_read[1], 1);
        cyc(); rst[1] = 0;
        @(negedge clk);
        chk("d5_no_done", cpu_done[1], 0);
        chk("d5_read0", mem_read[1], 0);
        chk("d5_write0", mem_write[1], 0);
        chk("d5_addr0", mem_addr[1], 32'h0);
        chk("d5_stall0", cpu_stall[1], 0);
        chk("d5_crd0", cpu_rdata[1], 32'h0);
        chk("d5_drd0", dbg_rdata[1], 32'h0);
        cyc();
        cpu_req[1] = 1; dbg_req[1] = 1; dbg_we[1] = 0; dbg_addr[1] = 32'h8;
        cyc();
        @(negedge clk);
        chk("d5_tie_cpu", cpu_gnt[1], 1);
        chk("d5_tie_dbg", dbg_gnt[1], 0);
        cyc(); cpu_req[1] = 0;
        found = -1;
        for (int w = 0; w < 10 && found < 0; w++) begin
            @(negedge clk);
            if (dbg_gnt[1]) found = w;
            cyc();
        end
        dbg_req[1] = 0;
        chk("d5_dbg_later", found >= 0, 1);

        // Back-to-back CPU reads, ACC=1
        ad = '{32'h0, 32'h4, 32'h8};
        exp_rd = '{32'h3C6E_F372, 32'h8C02_0000, 32'hCDD5_3EFA};
        rst[0] = 1;
        cyc(); rst[0] = 0;
        cpu_req[0] = 1; cpu_we[0] = 0; cpu_addr[0] = ad[0];
        nw = 0; nd = 0;
        for (int c = 0; c < 7; c++) begin
            if (c > 0) begin
                cyc();
                if (cpu_gnt[0]) begin
                    nw++;
                    if (nw < 3) cpu_addr[0] = ad[nw];
                    else        cpu_req[0] = 0;
                end
            end
            @(negedge clk);
            if (cpu_done[0]) begin
                if (nd < 3) chk($sformatf("d6_rdata_%0d", nd), cpu_rdata[0], exp_rd[nd]);
                nd++;
            end
        end
        chk("d6_done_count", nd, 3);

        // Random traffic on both instances
        cyc();
        for (int k = 0; k < 2; k++) begin
            cpu_req[k] = 0; dbg_req[k] = 0; dbg_lock[k] = 0; rst[k] = 1;
        end
        for (int n = 0; n < 4000; n++) begin
            cyc();
            for (int k = 0; k < 2; k++) begin
                rst[k] = ($urandom_range(299) == 0);
                if ($urandom_range(39) == 0) dbg_lock[k] = ~dbg_lock[k];
                if (cpu_gnt[k]) begin
                    if ($urandom_range(2) == 0) new_c(k);
                    else cpu_req[k] = 0;
                end else if (!cpu_req[k] && $urandom_range(3) == 0) begin
                    new_c(k);
                end
                if (dbg_gnt[k]) begin
                    if ($urandom_range(2) == 0) new_d(k);
                    else dbg_req[k] = 0;
                end else if (!dbg_req[k] && $urandom_range(3) == 0) begin
                    new_d(k);
                end
            end
        end
        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single unified instruction/data memory between the multi-cycle CPU datapath (port C) and a debug/program-loader port (port D).
- Serialises accesses and drives the memory's address, write-data and read/write strobes.
- Returns read data and a completion pulse to the winning requester.
- Produces a stall for the CPU controller, which holds its state/PC while the stall is high.

Parameters:
- ACC_CYCLES, 1, memory cycles per access (1..15); the memory is held stable for this many cycles.
- ADDR_W, 32, address width.
- DATA_W, 32, data width.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- cpu_req  in  1  CPU access request; level, held until cpu_gnt.
- cpu_we  in  1  1 = write, 0 = read; valid while cpu_req is high.
- cpu_addr  in  ADDR_W  CPU byte address.
- cpu_wdata  in  DATA_W  CPU write data.
- cpu_gnt  out  1  one-cycle pulse: CPU request accepted and latched.
- cpu_done  out  1  one-cycle pulse: CPU access complete.
- cpu_rdata  out  DATA_W  CPU read data; valid when cpu_done is high, held until the next CPU done.
- cpu_stall  out  1  high while the CPU has an unserved or in-flight access.
- dbg_req, dbg_we, dbg_addr, dbg_wdata  in  1/1/ADDR_W/DATA_W  same meaning as the CPU inputs, for port D.
- dbg_lock  in  1  high: port C is never granted; port D has exclusive access.
- dbg_gnt, dbg_done, dbg_rdata  out  1/1/DATA_W  same meaning as the CPU outputs, for port D.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_read  out  1  memory read strobe.
- mem_write  out  1  memory write strobe.
- mem_rdata  in  DATA_W  memory read data (combinational from mem_addr).

Behaviour:
- States: IDLE, ACCESS, DONE. Reset enters IDLE.
- Reset values: all outputs 0; owner = D, so the first tie goes to C; cycle counter = 0; rdata registers = 0.
- Arbitration happens in IDLE and DONE on the state registers plus the sampled req inputs:
  - Eligible C = cpu_req & ~dbg_lock; eligible D = dbg_req.
  - Only one eligible: grant it.
  - Both eligible: grant the port that is not owner (round-robin).
  - Winner: at the edge, latch addr/we/wdata, set owner, set counter = ACC_CYCLES-1, go to ACCESS.
  - No winner: go to or stay in IDLE.
- ACCESS:
  - The gnt of the owner is high in the first ACCESS cycle only.
  - mem_addr and mem_wdata come from the latches.
  - mem_read = ~we for every ACCESS cycle.
  - mem_write = we in the first ACCESS cycle only (exactly one write strobe per write).
  - Counter decrements each cycle; at 0, capture mem_rdata (reads only) into the owner's rdata register and go to DONE.
- DONE: the owner's done is high for one cycle; mem strobes are 0; arbitration for the next access runs in the same cycle.
- Latency from req sampled in IDLE: gnt at +1, done at +ACC_CYCLES+1. Back-to-back throughput is one access per ACC_CYCLES+1 cycles.
- Requester rules:
  - Drop req in the cycle after gnt is seen, or earlier.
  - req still high in the DONE cycle is a new request.
  - Inputs are ignored while the port's access is in flight.
- Write done: rdata is unchanged.
- cpu_stall = (cpu_req & ~(state==ACCESS & owner==C)) | (state==ACCESS & owner==C). It falls in the cpu_done cycle if cpu_req is low.
- dbg_lock rising while a C access is in ACCESS: that access completes normally; C is not granted again until lock falls. cpu_stall stays high for a pending cpu_req.
- Address bits are passed unchanged; no alignment or range checks.
- Reset mid-access: at the reset edge, ACCESS is aborted. mem_write/mem_read drop and no done pulse is issued; a write strobe already issued is not undone.
- ACC_CYCLES = 1: ACCESS lasts one cycle and gnt and the write strobe coincide.

Test Plan:
- Reset, then cpu_req=1, we=0, addr=0x00000004, mem returns 0x8C020000 (ACC_CYCLES=1) -> cpu_gnt at cycle 1, mem_read=1 with mem_addr=0x4 in cycle 1, cpu_done with cpu_rdata=0x8C020000 at cycle 2; cpu_stall high in cycles 0-1, low in cycle 2.
- Write: dbg_req=1, we=1, addr=0x00000100, wdata=0xDEADBEEF, ACC_CYCLES=3 -> mem_write high in exactly one cycle with that addr/data, mem_read=0 throughout, dbg_done 4 cycles after the req cycle, dbg_rdata unchanged.
- Simultaneous cpu_req and dbg_req held continuously, each re-requesting in DONE -> grants strictly alternate C, D, C, D starting with C; no port is granted twice in a row.
- dbg_lock=1 with cpu_req=1 for 10 cycles -> cpu_gnt never pulses and cpu_stall stays 1; dbg accesses proceed. Lock drops -> cpu_gnt in the next arbitration cycle.
- Reset asserted in the second ACCESS cycle of a CPU read (ACC_CYCLES=3) -> next cycle all outputs 0, no cpu_done, state IDLE, next tie goes to C.
- Back-to-back CPU reads at 0x0, 0x4, 0x8 with req re-raised in DONE (ACC_CYCLES=1) -> gnt/done alternate each cycle, three dones in 6 cycles, each rdata matching memory.
